// File: rtl/sobel_window_gen.sv
// Raster-to-window front end for the Sobel core: two line buffers feed a
// 3x3 shift array; only full interior windows are emitted.
module sobel_window_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pixel,
  output logic [PIX_W-1:0] p0,
  output logic [PIX_W-1:0] p1,
  output logic [PIX_W-1:0] p2,
  output logic [PIX_W-1:0] p3,
  output logic [PIX_W-1:0] p4,
  output logic [PIX_W-1:0] p5,
  output logic [PIX_W-1:0] p6,
  output logic [PIX_W-1:0] p7,
  output logic [PIX_W-1:0] p8,
  output logic             out_valid,
  output logic             out_eof
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] XMAX = CW'(IMG_W - 1);
  localparam logic [RW-1:0] YMAX = RW'(IMG_H - 1);
  localparam logic [CW-1:0] XMIN = CW'(2);
  localparam logic [RW-1:0] YMIN = RW'(2);

  logic [CW-1:0]    col_q, col_d, x;
  logic [RW-1:0]    row_q, row_d, y;
  logic [PIX_W-1:0] w_q [9];
  logic [PIX_W-1:0] w_d [9];
  logic [PIX_W-1:0] p_q [9];
  logic [PIX_W-1:0] p_d [9];
  logic             valid_q, valid_d;
  logic             eof_q, eof_d;

  logic [PIX_W-1:0] lb0 [IMG_W];
  logic [PIX_W-1:0] lb1 [IMG_W];
  logic [PIX_W-1:0] top, mid;

  // Start-of-frame overrides the counters for the pixel being accepted
  assign x   = in_sof ? '0 : col_q;
  assign y   = in_sof ? '0 : row_q;
  assign top = lb0[x];
  assign mid = lb1[x];

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    w_d     = w_q;
    p_d     = p_q;
    valid_d = 1'b0;
    eof_d   = 1'b0;
    if (in_valid) begin
      if (x == XMAX) begin
        col_d = '0;
        row_d = (y == YMAX) ? '0 : y + 1'b1;
      end else begin
        col_d = x + 1'b1;
        row_d = y;
      end
      w_d[0] = w_q[1];
      w_d[1] = w_q[2];
      w_d[2] = top;
      w_d[3] = w_q[4];
      w_d[4] = w_q[5];
      w_d[5] = mid;
      w_d[6] = w_q[7];
      w_d[7] = w_q[8];
      w_d[8] = in_pixel;
      if (x >= XMIN && y >= YMIN) begin
        valid_d = 1'b1;
        eof_d   = (x == XMAX) && (y == YMAX);
        p_d     = w_d;
      end
    end
  end

  // Line buffers are read-before-write and never reset
  always_ff @(posedge clk) begin
    if (in_valid) begin
      lb0[x] <= mid;
      lb1[x] <= in_pixel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      w_q     <= '{default: '0};
      p_q     <= '{default: '0};
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      w_q     <= w_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      eof_q   <= eof_d;
    end
  end

  assign p0        = p_q[0];
  assign p1        = p_q[1];
  assign p2        = p_q[2];
  assign p3        = p_q[3];
  assign p4        = p_q[4];
  assign p5        = p_q[5];
  assign p6        = p_q[6];
  assign p7        = p_q[7];
  assign p8        = p_q[8];
  assign out_valid = valid_q;
  assign out_eof   = eof_q;

endmodule

// File: tb/tb_sobel_window_gen.sv
// Scoreboard bench for sobel_window_gen on an 8x5 ramp image.
module tb_sobel_window_gen;

  localparam int W = 8;
  localparam int H = 5;

  typedef struct packed {
    logic            eof;
    logic [8:0][7:0] p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic [7:0] p0, p1, p2, p3, p4, p5, p6, p7, p8;
  logic       out_valid;
  logic       out_eof;
  logic [8:0][7:0] obs;

  exp_t sb[$];
  exp_t got;
  int   checks = 0;
  int   errors = 0;
  int   win_cnt = 0;
  int   eof_cnt = 0;
  int   obs_p0[$];
  int   obs_p8[$];
  int   mx = 0;
  int   my = 0;

  sobel_window_gen #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_sof(in_sof), .in_pixel(in_pixel),
    .p0(p0), .p1(p1), .p2(p2), .p3(p3), .p4(p4),
    .p5(p5), .p6(p6), .p7(p7), .p8(p8),
    .out_valid(out_valid), .out_eof(out_eof)
  );

  assign obs = {p8, p7, p6, p5, p4, p3, p2, p1, p0};

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [71:0] act, logic [71:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard side: every cycle out_valid must match a pending window
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("valid", 72'(out_valid), 72'(sb.size() > 0));
      if (out_valid && sb.size() > 0) begin
        got = sb.pop_front();
        chk("window", 72'(obs), 72'(got.p));
        chk("eof", 72'(out_eof), 72'(got.eof));
        win_cnt++;
        if (out_eof) eof_cnt++;
        obs_p0.push_back(int'(p0));
        obs_p8.push_back(int'(p8));
      end
    end
  end

  task automatic drive(bit v, bit s, logic [7:0] pix, int base);
    int x, y;
    exp_t ne;
    @(negedge clk);
    in_valid = v;
    in_sof   = s;
    in_pixel = pix;
    if (v) begin
      x = s ? 0 : mx;
      y = s ? 0 : my;
      if (x >= 2 && y >= 2) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            ne.p[r*3+c] = 8'(base + 10*(y-2+r) + (x-2+c));
        ne.eof = (x == W-1) && (y == H-1);
        sb.push_back(ne);
      end
      mx = (x == W-1) ? 0 : x + 1;
      my = (x == W-1) ? ((y == H-1) ? 0 : y + 1) : y;
    end
    @(posedge clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 0);
  endtask

  task automatic send_img(int base, int maxgap, int n, bit first_sof);
    for (int i = 0; i < n; i++) begin
      if (maxgap > 0)
        repeat ($urandom_range(0, maxgap))
          drive(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 0);
      drive(1'b1, (i == 0) && first_sof,
            8'(base + 10*(i/W) + (i%W)), base);
    end
  endtask

  task automatic clr_stats();
    win_cnt = 0;
    eof_cnt = 0;
    obs_p0.delete();
    obs_p8.delete();
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = 8'h00;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_p", 72'(obs), 72'(0));
    chk("rst_valid", 72'(out_valid), 72'(0));
    chk("rst_eof", 72'(out_eof), 72'(0));
    rst = 1'b0;

    // T1/T2 ramp, no gaps, first pixel after reset is (0,0)
    clr_stats();
    send_img(0, 0, W*H, 1'b0);
    idle(2);
    chk("t1_count", 72'(win_cnt), 72'(18));
    chk("t1_eofs", 72'(eof_cnt), 72'(1));
    chk("t1_first_p0", 72'(obs_p0[0]), 72'(0));
    chk("t1_first_p8", 72'(obs_p8[0]), 72'(22));
    chk("t1_last_p8", 72'(obs_p8[17]), 72'(47));
    chk("t2_row3_p0", 72'(obs_p0[6]), 72'(10));
    chk("t2_row3_p8", 72'(obs_p8[6]), 72'(32));

    // T3 random gaps
    clr_stats();
    send_img(0, 5, W*H, 1'b1);
    idle(2);
    chk("t3_count", 72'(win_cnt), 72'(18));
    chk("t3_eofs", 72'(eof_cnt), 72'(1));

    // T4 back-to-back frames
    clr_stats();
    send_img(0, 0, W*H, 1'b1);
    send_img(100, 0, W*H, 1'b1);
    idle(2);
    chk("t4_count", 72'(win_cnt), 72'(36));
    chk("t4_eofs", 72'(eof_cnt), 72'(2));
    chk("t4_f2_p0", 72'(obs_p0[18]), 72'(100));
    chk("t4_f2_p8", 72'(obs_p8[18]), 72'(122));

    // T5 in_sof arrives at (4,3)
    clr_stats();
    send_img(0, 0, 3*W + 4, 1'b1);
    send_img(0, 0, W*H, 1'b1);
    idle(2);
    chk("t5_count", 72'(win_cnt), 72'(26));
    chk("t5_eofs", 72'(eof_cnt), 72'(1));
    chk("t5_new_p0", 72'(obs_p0[8]), 72'(0));
    chk("t5_new_p8", 72'(obs_p8[8]), 72'(22));

    // T6 async reset mid-row, between edges
    send_img(0, 0, W + 5, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_p", 72'(obs), 72'(0));
    chk("t6_valid", 72'(out_valid), 72'(0));
    chk("t6_eof", 72'(out_eof), 72'(0));
    sb.delete();
    mx = 0;
    my = 0;
    #1;
    rst = 1'b0;
    clr_stats();
    send_img(0, 0, W*H, 1'b0);
    idle(2);
    chk("t6_count", 72'(win_cnt), 72'(18));
    chk("t6_eofs", 72'(eof_cnt), 72'(1));
    chk("t6_first_p8", 72'(obs_p8[0]), 72'(22));
    chk("t6_last_p8", 72'(obs_p8[17]), 72'(47));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
